// File: rtl/vga_rgb_out.sv
// VGA timing generator (640x480@60 default) that shows one colour per frame, sampled at each frame wrap.
// Define VGA_BORDER_EN to draw a white one-pixel border around the active area.
module vga_rgb_out #(
    parameter int DIV      = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [2:0] rgb_in,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       pix_tick,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);
    localparam logic [9:0]    H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]    VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]    X_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0]    Y_ACT    = 10'(V_ACTIVE);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic          hsync_q, vsync_q, video_on_q;
    logic [2:0]    rgb_q;

    logic          tick, x_wrap, y_wrap, fs;
    logic          hs_n, vs_n, von;
    logic [2:0]    pix_rgb;

    // Gating with clr_n keeps the tick low in reset even when DIV=1.
    assign tick   = clr_n && (div_q == DIV_MAX);
    assign x_wrap = (x_q == H_MAX);
    assign y_wrap = (y_q == V_MAX);
    assign fs     = tick && x_wrap && y_wrap;

    always_comb begin
        div_d    = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = fs ? rgb_in : colour_q;
        if (tick) begin
            if (x_wrap) begin
                x_d = 10'd0;
                y_d = y_wrap ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_comb begin
        hs_n    = !((x_q >= HS_START) && (x_q < HS_END));
        vs_n    = !((y_q >= VS_START) && (y_q < VS_END));
        von     = (x_q < X_ACT) && (y_q < Y_ACT);
        pix_rgb = von ? colour_q : 3'b000;
`ifdef VGA_BORDER_EN
        if (von && ((x_q == 10'd0) || (x_q == X_ACT - 10'd1) ||
                    (y_q == 10'd0) || (y_q == Y_ACT - 10'd1))) begin
            pix_rgb = 3'b111;
        end
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            div_q      <= '0;
            x_q        <= 10'd0;
            y_q        <= 10'd0;
            colour_q   <= 3'b000;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
            rgb_q      <= 3'b000;
        end else begin
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            hsync_q    <= hs_n;
            vsync_q    <= vs_n;
            video_on_q <= von;
            rgb_q      <= pix_rgb;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign rgb         = rgb_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign pix_tick    = tick;
    assign frame_start = fs;

endmodule

// File: tb/tb_vga_rgb_out.sv
// Directed bench for vga_rgb_out on a shrunken raster (16x11 pixels, DIV=2) so whole frames fit in a short run.
module tb_vga_rgb_out;
    localparam int DIV   = 2;
    localparam int HT    = 16;
    localparam int FPIX  = 176;
    localparam int NRUN  = 1106;

`ifdef VGA_BORDER_EN
    localparam logic [2:0] BRD = 3'b111;
`else
    localparam logic [2:0] BRD = 3'b000;
`endif

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic [2:0] rgb_in = 3'b000;
    logic       hsync, vsync, video_on, pix_tick, frame_start;
    logic [2:0] rgb;
    logic [9:0] pixel_x, pixel_y;

    int tests = 0;
    int fails = 0;

    vga_rgb_out #(
        .DIV(DIV), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dut (
        .clk(clk), .clr_n(clr_n), .rgb_in(rgb_in),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pix_tick(pix_tick), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected {hsync, vsync, video_on, rgb} one clk after the raster sat at linear pixel lin.
    function automatic logic [5:0] model_out(input int lin, input logic [2:0] col);
        int x, y;
        logic hs, vs, von;
        logic [2:0] c;
        x   = lin % HT;
        y   = lin / HT;
        hs  = !(x >= 10 && x <= 12);
        vs  = !(y >= 7 && y <= 8);
        von = (x < 8) && (y < 6);
        c   = von ? col : 3'b000;
`ifdef VGA_BORDER_EN
        if (von && (x == 0 || x == 7 || y == 0 || y == 5)) c = 3'b111;
`endif
        return {hs, vs, von, c};
    endfunction

    int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$], fs_at[$];

    initial begin
        int lin, lin_p, err_cnt, err_reg, x10_n, vo_line, f0_bad, f1_tear, fs_double, waited;
        int hs_period, hs_width, vs_period, vs_width, fs_period, hs_lag;
        logic fs_p, exp_tick, exp_fs, prev_hs, prev_vs, prev_fs;
        logic [9:0] prev_x;
        logic [2:0] mcol;
        logic [5:0] exp_o;

        err_cnt = 0; err_reg = 0; x10_n = -1; vo_line = 0; f0_bad = 0;
        f1_tear = 0; fs_double = 0;
        prev_hs = 1'b1; prev_vs = 1'b1; prev_fs = 1'b0; prev_x = 10'd0;

        repeat (10) @(negedge clk);
        check_eq("rst_hsync", hsync, 1);
        check_eq("rst_vsync", vsync, 1);
        check_eq("rst_rgb", rgb, 0);
        check_eq("rst_video_on", video_on, 0);
        check_eq("rst_pixel_x", pixel_x, 0);
        check_eq("rst_pixel_y", pixel_y, 0);
        check_eq("rst_pix_tick", pix_tick, 0);
        check_eq("rst_frame_start", frame_start, 0);
        $display("[TB] reset state checked");

        clr_n = 1'b1;
        mcol  = 3'b000;
        for (int n = 1; n <= NRUN; n++) begin
            @(posedge clk);
            lin_p = ((n - 1) / DIV) % FPIX;
            fs_p  = (((n - 1) % DIV) == DIV - 1) && (lin_p == FPIX - 1);
            exp_o = model_out(lin_p, mcol);
            if (fs_p) mcol = rgb_in;
            @(negedge clk);
            lin      = (n / DIV) % FPIX;
            exp_tick = ((n % DIV) == DIV - 1);
            exp_fs   = exp_tick && (lin == FPIX - 1);
            if (pixel_x !== 10'(lin % HT) || pixel_y !== 10'(lin / HT) ||
                pix_tick !== exp_tick || frame_start !== exp_fs) err_cnt++;
            if ({hsync, vsync, video_on, rgb} !== exp_o) err_reg++;

            if (prev_hs && !hsync) hs_fall.push_back(n);
            if (!prev_hs && hsync) hs_rise.push_back(n);
            if (prev_vs && !vsync) vs_fall.push_back(n);
            if (!prev_vs && vsync) vs_rise.push_back(n);
            if (frame_start) fs_at.push_back(n);
            if (prev_fs && frame_start) fs_double++;
            if (x10_n < 0 && prev_x == 10'd9 && pixel_x == 10'd10) x10_n = n;
            if (hs_fall.size() == 1 && video_on) vo_line++;
            if (n <= 352 && rgb != 3'b000 && rgb != BRD) f0_bad++;
            if (n >= 353 && n <= 704 && video_on && rgb != 3'b101 && rgb != BRD) f1_tear++;
            prev_hs = hsync; prev_vs = vsync; prev_fs = frame_start; prev_x = pixel_x;

            if (n == 353) check_eq("f1_rgb_at_0_0", rgb, (BRD == 3'b111) ? 3'b111 : 3'b101);
            if (n == 359) check_eq("f1_rgb_at_3_0", rgb, (BRD == 3'b111) ? 3'b111 : 3'b101);
            if (n == 369) check_eq("f1_rgb_at_8_0", rgb, 3'b000);
            if (n == 387) check_eq("f1_rgb_at_1_1", rgb, 3'b101);
            if (n == 417) check_eq("f1_rgb_at_0_2", rgb, (BRD == 3'b111) ? 3'b111 : 3'b101);
            if (n == 431) check_eq("f1_rgb_at_7_2", rgb, (BRD == 3'b111) ? 3'b111 : 3'b101);
            if (n == 519) check_eq("f1_rgb_at_3_5", rgb, (BRD == 3'b111) ? 3'b111 : 3'b101);
            if (n == 545) check_eq("f1_rgb_at_0_6", rgb, 3'b000);
            if (n == 739) check_eq("f2_rgb_at_1_1", rgb, 3'b010);

            // Colour appears mid-frame 0, then toggles through frame 1.
            if (n == 100) rgb_in = 3'b101;
            if (n >= 360 && n <= 700 && ((n - 360) % 10) == 0) rgb_in = ~rgb_in;
        end
        $display("[TB] %0d frames streamed", NRUN / (FPIX * DIV));

        check_eq("counter_mismatch_cycles", err_cnt, 0);
        check_eq("output_mismatch_cycles", err_reg, 0);
        hs_period = (hs_fall.size() >= 2) ? hs_fall[1] - hs_fall[0] : -1;
        hs_width  = (hs_fall.size() >= 1 && hs_rise.size() >= 1) ? hs_rise[0] - hs_fall[0] : -1;
        hs_lag    = (hs_fall.size() >= 1) ? hs_fall[0] - x10_n : -1;
        vs_period = (vs_fall.size() >= 2) ? vs_fall[1] - vs_fall[0] : -1;
        vs_width  = (vs_fall.size() >= 1 && vs_rise.size() >= 1) ? vs_rise[0] - vs_fall[0] : -1;
        fs_period = (fs_at.size() >= 2) ? fs_at[1] - fs_at[0] : -1;
        check_eq("hsync_period", hs_period, 32);
        check_eq("hsync_low_width", hs_width, 6);
        check_eq("hsync_fall_lag", hs_lag, 1);
        check_eq("video_on_per_line", vo_line, 16);
        check_eq("vsync_period", vs_period, 352);
        check_eq("vsync_low_width", vs_width, 64);
        check_eq("vsync_first_fall", (vs_fall.size() >= 1) ? vs_fall[0] : -1, 225);
        check_eq("frame_start_count", fs_at.size(), 3);
        check_eq("frame_start_period", fs_period, 352);
        check_eq("frame_start_double", fs_double, 0);
        check_eq("frame0_not_black", f0_bad, 0);
        check_eq("frame1_tearing", f1_tear, 0);
        $display("[TB] timing measurements checked");

        waited = 0;
        while (pixel_x != 10'd5 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("wait_mid_line", pixel_x, 5);
        #2 clr_n = 1'b0;
        #1;
        check_eq("async_rst_outputs", {hsync, vsync, video_on, rgb}, 6'b110000);
        check_eq("async_rst_counters", {pixel_x, pixel_y}, 0);
        check_eq("async_rst_pulses", {pix_tick, frame_start}, 0);
        $display("[TB] asynchronous reset mid-line checked");

        repeat (3) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
        check_eq("restart_x_edge1", pixel_x, 0);
        check_eq("restart_tick_edge1", pix_tick, 1);
        @(negedge clk);
        check_eq("restart_x_edge2", pixel_x, 1);
        check_eq("restart_tick_edge2", pix_tick, 0);
        check_eq("restart_video_on", video_on, 1);
        check_eq("restart_rgb", rgb, BRD);
        $display("[TB] restart after reset checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
